// File: rtl/alu_pkg.sv
// Shared opcode encodings and default sizes for the execute-stage ALU.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package alu_pkg;

  localparam int ALU_OP_W   = 3;
  localparam int ALU_DATA_W = 16;

  localparam logic [ALU_OP_W-1:0] ALU_NOP = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SHL = 3'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SHR = 3'd6;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'd7;

endpackage

// File: rtl/alu_shifter.sv
// Combinational logical barrel shifter (left or right, zero fill).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs continuously.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DATA_W
) (
  input  logic [WIDTH-1:0] i_dat,
  input  logic [WIDTH-1:0] i_amt,
  input  logic             i_dir_right,
  output logic [WIDTH-1:0] o_dat
);

  // Amount compared at the amount's own width so no extension is needed.
  localparam logic [WIDTH-1:0] LP_WIDTH = WIDTH[WIDTH-1:0];

  logic w_oversize;

  assign w_oversize = (i_amt >= LP_WIDTH);

  // Oversized amounts (which include every negative B seen as unsigned) flush to zero.
  always_comb begin
    o_dat = '0;
    if (!w_oversize) begin
      if (i_dir_right) begin
        o_dat = i_dat >> i_amt;
      end else begin
        o_dat = i_dat << i_amt;
      end
    end
  end

endmodule

// File: rtl/alu.sv
// Registered 8-op integer ALU (add/sub/or/and/shl/shr/xor/nop); optional ZeroFlag via ALU_ZERO_FLAG_EN.
// Latency: 1 cycle from operand sampling edge to OutputData.
// Backpressure: none; a new operation is accepted on every clock edge.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DATA_W
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic signed [WIDTH-1:0] FirstInput,
  input  logic signed [WIDTH-1:0] SecondInput,
  input  logic [ALU_OP_W-1:0]     ALUOp,
  output logic signed [WIDTH-1:0] OutputData
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic                    ZeroFlag
`endif
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_shift;
  logic             w_shift_right;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] r_result;

  // Two's-complement wrap comes for free by keeping results at WIDTH bits.
  assign w_sum         = FirstInput + SecondInput;
  assign w_diff        = FirstInput - SecondInput;
  assign w_shift_right = (ALUOp == ALU_SHR);

  alu_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .i_dat       (FirstInput),
    .i_amt       (SecondInput),
    .i_dir_right (w_shift_right),
    .o_dat       (w_shift)
  );

  // Opcode select; NOP deliberately produces zero rather than holding.
  always_comb begin
    w_result = '0;
    case (ALUOp)
      ALU_NOP: w_result = '0;
      ALU_ADD: w_result = w_sum;
      ALU_SUB: w_result = w_diff;
      ALU_OR:  w_result = FirstInput | SecondInput;
      ALU_AND: w_result = FirstInput & SecondInput;
      ALU_SHL: w_result = w_shift;
      ALU_SHR: w_result = w_shift;
      ALU_XOR: w_result = FirstInput ^ SecondInput;
      default: w_result = '0;
    endcase
  end

  // Output register; reset wins over whatever operation is presented.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_result <= '0;
    end else begin
      r_result <= w_result;
    end
  end

  assign OutputData = r_result;

`ifdef ALU_ZERO_FLAG_EN
  logic r_zero;

  // Flag tracks the value being loaded into the result register on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_zero <= 1'b1;
    end else begin
      r_zero <= (w_result == '0);
    end
  end

  assign ZeroFlag = r_zero;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver pushes expected results, monitor pops and compares each cycle.
// Latency: expects each result one rising edge after its inputs are sampled.
// Backpressure: none; stimulus is issued every cycle on the falling edge.
module tb_alu;
  import alu_pkg::*;

  localparam int W = 16;

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic signed [W-1:0] FirstInput = '0;
  logic signed [W-1:0] SecondInput = '0;
  logic [ALU_OP_W-1:0] ALUOp = '0;
  logic signed [W-1:0] OutputData;
`ifdef ALU_ZERO_FLAG_EN
  logic                ZeroFlag;
`endif

  always #5 CLK = ~CLK;

  alu #(
    .WIDTH (W)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .FirstInput  (FirstInput),
    .SecondInput (SecondInput),
    .ALUOp       (ALUOp),
    .OutputData  (OutputData)
`ifdef ALU_ZERO_FLAG_EN
    ,
    .ZeroFlag    (ZeroFlag)
`endif
  );

  typedef struct {
    logic [W-1:0] res;
    logic         zf;
    string        tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reduce any integer to its 16-bit two's-complement pattern.
  function automatic logic [W-1:0] to_w(longint v);
    longint m;
    m = ((v % 65536) + 65536) % 65536;
    return m[W-1:0];
  endfunction

  // Reference: the arithmetic meaning of each opcode on integer values.
  function automatic logic [W-1:0] model(int op, int a, int b);
    longint ua;
    longint ub;
    longint r;
    ua = (a < 0) ? a + 65536 : a;
    ub = (b < 0) ? b + 65536 : b;
    case (op)
      1:       r = longint'(a) + b;
      2:       r = longint'(a) - b;
      3:       r = ua | ub;
      4:       r = ua & ub;
      5:       r = (ub >= 16) ? 0 : ua * (longint'(1) << ub);
      6:       r = (ub >= 16) ? 0 : ua / (longint'(1) << ub);
      7:       r = ua ^ ub;
      default: r = 0;
    endcase
    return to_w(r);
  endfunction

  function automatic int sext(int raw);
    return (raw >= 32768) ? raw - 65536 : raw;
  endfunction

  // Drive one operation on the falling edge and record what must come out.
  task automatic issue(input int op, input int a, input int b, input bit rst,
                       input logic [W-1:0] exp_res, input string tag);
    exp_t e;
    @(negedge CLK);
    RST         = rst;
    ALUOp       = op[ALU_OP_W-1:0];
    FirstInput  = W'(a);
    SecondInput = W'(b);
    e.res = rst ? '0 : exp_res;
    e.zf  = (e.res == '0);
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Directed case: expected value is the hand-written integer.
  task automatic dchk(input int op, input int a, input int b, input int exp_val);
    issue(op, a, b, 1'b0, to_w(exp_val), $sformatf("op%0d(%0d,%0d)", op, a, b));
  endtask

  // Monitor: every rising edge with an outstanding expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (OutputData !== e.res) begin
          errors++;
          $display("FAIL %s: OutputData=%0d expected %0d", e.tag, $signed(OutputData), $signed(e.res));
        end
`ifdef ALU_ZERO_FLAG_EN
        checks++;
        if (ZeroFlag !== e.zf) begin
          errors++;
          $display("FAIL %s zeroflag: ZeroFlag=%b expected %b", e.tag, ZeroFlag, e.zf);
        end
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int op;
    int a;
    int b;
    bit r;

    // Reset, with a live ADD on the bus to show reset priority.
    issue(1, 7, 9, 1'b1, '0, "reset");

    // NOP always loads zero.
    dchk(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      dchk(0, sext($urandom_range(0, 65535)), sext($urandom_range(0, 65535)), 0);
    end

    dchk(1, 1, 1, 2);
    dchk(1, 15, 28, 43);
    dchk(1, -13, 4, -9);
    dchk(1, -3, -5, -8);
    dchk(1, 32767, 1, -32768);

    dchk(2, 1, 1, 0);
    dchk(2, 15, 28, -13);
    dchk(2, -13, 4, -17);
    dchk(2, 13, -4, 17);
    dchk(2, -3, -5, 2);
    dchk(2, 5, 5, 0);

    dchk(3, 1, 2, 3);
    dchk(3, -15, 4, -11);
    dchk(3, 0, 0, 0);
    dchk(4, 1, 2, 0);
    dchk(4, -15, 4, 0);
    dchk(4, -15, 3, 1);
    dchk(7, 1, 2, 3);
    dchk(7, -15, 4, -11);
    dchk(7, -15, 3, -14);

    dchk(5, 1, 1, 2);
    dchk(5, 10, 1, 20);
    dchk(5, -4, 3, -32);
    dchk(5, 0, sext($urandom_range(0, 65535)), 0);
    dchk(5, 1, 16, 0);
    dchk(5, 5, 0, 5);
    dchk(5, 1, -1, 0);
    dchk(5, 1, 15, -32768);
    dchk(6, 2, 1, 1);
    dchk(6, 10, 1, 5);
    dchk(6, -8, 3, 8191);
    dchk(6, 0, sext($urandom_range(0, 65535)), 0);
    dchk(6, -8, 0, -8);
    dchk(6, -1, 16, 0);
    dchk(6, -1, 15, 1);
    dchk(1, 1, 1, 2);

    // Back-to-back ops, then a reset landing on a SUB that must never show.
    dchk(1, 100, 23, 123);
    dchk(2, 100, 23, 77);
    dchk(1, 3, 4, 7);
    issue(2, 9, 2, 1'b1, to_w(7), "reset_mid_sub");
    dchk(1, 1, 1, 2);

    // Randomized stream against the reference model.
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 7);
      a  = sext($urandom_range(0, 65535));
      b  = (($urandom_range(0, 1) == 1) && (op == 5 || op == 6))
           ? $urandom_range(0, 20) : sext($urandom_range(0, 65535));
      r  = ($urandom_range(0, 15) == 0);
      issue(op, a, b, r, model(op, a, b), $sformatf("rand%0d op%0d(%0d,%0d) rst=%0d", i, op, a, b, r));
    end

    @(negedge CLK);
    RST   = 1'b0;
    ALUOp = '0;
    repeat (3) @(posedge CLK);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
